// File: rtl/jhash_mix.sv
// Jenkins lookup2 mix engine: absorbs 3-word groups, folds in the length and emits the hash.
// Define JHASH_MIX_UNROLL_EN to compute all three mix rounds in a single cycle.
module jhash_mix (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] initval,
  input  logic [31:0] stream_data0,
  input  logic [31:0] stream_data1,
  input  logic [31:0] stream_data2,
  input  logic        stream_valid,
  input  logic        stream_done,
  input  logic [1:0]  stream_left,
  output logic        stream_ack,
  output logic [31:0] hash_out,
  output logic        hash_valid,
  input  logic        hash_ack
);

  localparam logic [31:0] Golden = 32'h9e3779b9;

  typedef enum logic [1:0] {StAbsorb, StMix, StFmix, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0] len_q, len_d;
  logic [31:0] hash_q, hash_d;
  logic [31:0] fold_c;
  logic [95:0] mixed;
  logic        mix_last;

  // One lookup2 round; each step uses the values already updated earlier in the round.
  function automatic logic [95:0] mix_round(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [4:0] s3);
    logic [31:0] an, bn, cn;
    an = (a - b - c) ^ (c >> s1);
    bn = (b - c - an) ^ (an << s2);
    cn = (c - an - bn) ^ (bn >> s3);
    return {an, bn, cn};
  endfunction

`ifdef JHASH_MIX_UNROLL_EN
  logic [95:0] r0, r1;

  assign r0       = mix_round(a_q, b_q, c_q, 5'd13, 5'd8, 5'd13);
  assign r1       = mix_round(r0[95:64], r0[63:32], r0[31:0], 5'd12, 5'd16, 5'd5);
  assign mixed    = mix_round(r1[95:64], r1[63:32], r1[31:0], 5'd3, 5'd10, 5'd15);
  assign mix_last = 1'b1;
`else
  logic [1:0] rnd_q, rnd_d;
  logic [4:0] s1, s2, s3;

  always_comb begin
    case (rnd_q)
      2'd0:    {s1, s2, s3} = {5'd13, 5'd8, 5'd13};
      2'd1:    {s1, s2, s3} = {5'd12, 5'd16, 5'd5};
      default: {s1, s2, s3} = {5'd3, 5'd10, 5'd15};
    endcase
  end

  assign mixed    = mix_round(a_q, b_q, c_q, s1, s2, s3);
  assign mix_last = (rnd_q == 2'd2);
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    len_d      = len_q;
    hash_d     = hash_q;
    stream_ack = 1'b0;
`ifndef JHASH_MIX_UNROLL_EN
    rnd_d      = rnd_q;
`endif
    // Byte length of the whole message, folded into c before the tail words.
    fold_c     = c_q + ((len_q + {30'd0, stream_left}) << 2);

    unique case (state_q)
      StAbsorb: begin
        if (stream_done) begin
          stream_ack = ce & ~rst;
          if (stream_left != 2'd0) a_d = a_q + stream_data0;
          if (stream_left >= 2'd2) b_d = b_q + stream_data1;
          c_d     = (stream_left == 2'd3) ? fold_c + stream_data2 : fold_c;
          state_d = StFmix;
`ifndef JHASH_MIX_UNROLL_EN
          rnd_d   = 2'd0;
`endif
        end else if (stream_valid) begin
          stream_ack = ce & ~rst;
          a_d        = a_q + stream_data0;
          b_d        = b_q + stream_data1;
          c_d        = c_q + stream_data2;
          len_d      = len_q + 32'd3;
          state_d    = StMix;
`ifndef JHASH_MIX_UNROLL_EN
          rnd_d      = 2'd0;
`endif
        end
      end
      StMix, StFmix: begin
        {a_d, b_d, c_d} = mixed;
`ifndef JHASH_MIX_UNROLL_EN
        rnd_d = mix_last ? 2'd0 : rnd_q + 2'd1;
`endif
        if (mix_last) begin
          if (state_q == StFmix) begin
            state_d = StDone;
            hash_d  = mixed[31:0];
          end else begin
            state_d = StAbsorb;
          end
        end
      end
      StDone: begin
        if (hash_ack) begin
          a_d     = Golden;
          b_d     = Golden;
          c_d     = initval;
          len_d   = 32'd0;
          state_d = StAbsorb;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAbsorb;
      a_q     <= Golden;
      b_q     <= Golden;
      c_q     <= initval;
      len_q   <= 32'd0;
      hash_q  <= 32'd0;
`ifndef JHASH_MIX_UNROLL_EN
      rnd_q   <= 2'd0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      len_q   <= len_d;
      hash_q  <= hash_d;
`ifndef JHASH_MIX_UNROLL_EN
      rnd_q   <= rnd_d;
`endif
    end
  end

  assign hash_out   = hash_q;
  assign hash_valid = (state_q == StDone);

endmodule
